csr_stream_host: RTL and testbench

- Host-side transmitter for the sparse MVM accelerator's CPU load interface.
- Holds a CSR entry table written by the system (row pointer, column index, value per non-zero) and a 3-bit spike train.
- On go, it streams the table to the accelerator using the accelerator's sending_CPU/FETCH_ready/done_list handshake, sends the spike train, then decodes the accelerator's toggle-signalled result stream into three result registers.

---
 rtl/csr_stream_host.sv | 215 +++++++++++++++++++++
 tb/tb_csr_stream_host.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_stream_host.sv
// csr_stream_host
//   Host-side transmitter for the sparse MVM accelerator's CPU load port.
//   Holds a CSR entry table plus a 3-bit spike train. On go it streams the
//   table entries, sends done_list and then the train. It then decodes the
//   accelerator's toggle-signalled result stream into res0..res2.
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   cfg_we/addr/row/col/val  table write port (honoured only while idle)
//   nnz_count, train_in, go  launch controls (sampled on accepted go)
//   busy, done, error        run status (done/error are one-cycle pulses)
//   res0..res2               captured row results
//   acc_*                    accelerator load/result handshake
module csr_stream_host #(
    parameter int MAX_NNZ = 9,
    parameter int TIMEOUT = 255,
    parameter int TW      = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cfg_we,
    input  logic [3:0] cfg_addr,
    input  logic [1:0] cfg_row,
    input  logic [1:0] cfg_col,
    input  logic [7:0] cfg_val,
    input  logic [3:0] nnz_count,
    input  logic [2:0] train_in,
    input  logic       go,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [7:0] res0,
    output logic [7:0] res1,
    output logic [7:0] res2,
    output logic       acc_start,
    output logic [1:0] acc_row_val,
    output logic [1:0] acc_column_val,
    output logic [7:0] acc_value,
    output logic       acc_sending_cpu,
    output logic       acc_done_list,
    input  logic       acc_fetch_ready,
    input  logic [7:0] acc_output_val,
    input  logic       acc_sending_out
);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_START    = 4'd1;
    localparam logic [3:0] S_WAIT_RDY = 4'd2;
    localparam logic [3:0] S_SEND     = 4'd3;
    localparam logic [3:0] S_GAP      = 4'd4;
    localparam logic [3:0] S_WAIT_DL  = 4'd5;
    localparam logic [3:0] S_GAP2     = 4'd6;
    localparam logic [3:0] S_WAIT_TRN = 4'd7;
    localparam logic [3:0] S_SEND_TRN = 4'd8;
    localparam logic [3:0] S_COLLECT  = 4'd9;

    localparam logic [3:0]    NNZ_MAX = 4'(MAX_NNZ);
    localparam logic [TW-1:0] TMO_LIM = TW'(TIMEOUT);

    // Table storage is intentionally not reset.
    logic [1:0] tbl_row_q [MAX_NNZ];
    logic [1:0] tbl_col_q [MAX_NNZ];
    logic [7:0] tbl_val_q [MAX_NNZ];

    logic [3:0]      state_q, state_d;
    logic [3:0]      idx_q, idx_d;
    logic [3:0]      nnz_q, nnz_d;
    logic [2:0]      train_q, train_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [1:0]      cnt_q, cnt_d;
    logic            hdr_q, hdr_d;
    logic            hist_q;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [7:0]      cap0_q, cap0_d, cap1_q, cap1_d;
    logic [2:0][7:0] res_q, res_d;
    logic            tmo_inc;
    logic            toggle;

    assign toggle = acc_sending_out ^ hist_q;

    always_ff @(posedge clk) begin
        if (cfg_we && state_q == S_IDLE && cfg_addr < NNZ_MAX) begin
            tbl_row_q[cfg_addr] <= cfg_row;
            tbl_col_q[cfg_addr] <= cfg_col;
            tbl_val_q[cfg_addr] <= cfg_val;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        nnz_d   = nnz_q;
        train_d = train_q;
        cnt_d   = cnt_q;
        hdr_d   = hdr_q;
        cap0_d  = cap0_q;
        cap1_d  = cap1_q;
        res_d   = res_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        tmo_inc = 1'b0;
        case (state_q)
            S_IDLE: if (go) begin
                train_d = train_in;
                nnz_d   = (nnz_count > NNZ_MAX) ? NNZ_MAX : nnz_count;
                idx_d   = 4'd0;
                state_d = S_START;
            end
            S_START:    state_d = (nnz_q != 4'd0) ? S_WAIT_RDY : S_WAIT_DL;
            S_WAIT_RDY: if (acc_fetch_ready) state_d = S_SEND; else tmo_inc = 1'b1;
            S_SEND: begin
                idx_d   = idx_q + 4'd1;
                state_d = S_GAP;
            end
            // GAP covers the accelerator's ready-low cycle after each strobe.
            S_GAP:      state_d = (idx_q < nnz_q) ? S_WAIT_RDY : S_WAIT_DL;
            S_WAIT_DL:  if (acc_fetch_ready) state_d = S_GAP2; else tmo_inc = 1'b1;
            S_GAP2:     state_d = S_WAIT_TRN;
            S_WAIT_TRN: if (acc_fetch_ready) state_d = S_SEND_TRN; else tmo_inc = 1'b1;
            S_SEND_TRN: begin
                cnt_d   = 2'd0;
                hdr_d   = 1'b0;
                state_d = S_COLLECT;
            end
            S_COLLECT: begin
                tmo_inc = 1'b1;
                if (toggle) begin
                    if (!hdr_q) begin
                        hdr_d = 1'b1;  // header toggle carries no data
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                        case (cnt_q)
                            2'd0:    cap0_d = acc_output_val;
                            2'd1:    cap1_d = acc_output_val;
                            default: begin
                                // Results commit together so an abort leaves res untouched.
                                res_d   = {acc_output_val, cap1_q, cap0_q};
                                done_d  = 1'b1;
                                tmo_inc = 1'b0;
                                state_d = S_IDLE;
                            end
                        endcase
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (tmo_inc && (tmo_q + 1'b1) == TMO_LIM) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
        end

        if (state_d != state_q) tmo_d = '0;
        else if (tmo_inc)       tmo_d = tmo_q + 1'b1;
        else                    tmo_d = tmo_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            nnz_q   <= '0;
            train_q <= '0;
            tmo_q   <= '0;
            cnt_q   <= '0;
            hdr_q   <= 1'b0;
            hist_q  <= 1'b1;  // accelerator idles with sending_out high
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cap0_q  <= '0;
            cap1_q  <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            nnz_q   <= nnz_d;
            train_q <= train_d;
            tmo_q   <= tmo_d;
            cnt_q   <= cnt_d;
            hdr_q   <= hdr_d;
            hist_q  <= acc_sending_out;
            done_q  <= done_d;
            err_q   <= err_d;
            cap0_q  <= cap0_d;
            cap1_q  <= cap1_d;
            res_q   <= res_d;
        end
    end

    assign busy            = (state_q != S_IDLE);
    assign done            = done_q;
    assign error           = err_q;
    assign res0            = res_q[0];
    assign res1            = res_q[1];
    assign res2            = res_q[2];
    assign acc_start       = (state_q == S_START);
    assign acc_sending_cpu = (state_q == S_SEND) || (state_q == S_SEND_TRN);
    assign acc_done_list   = (state_q == S_WAIT_DL) && acc_fetch_ready;

    // Data lines stay at zero unless a send strobe is up.
    always_comb begin
        acc_row_val    = 2'd0;
        acc_column_val = 2'd0;
        acc_value      = 8'd0;
        if (state_q == S_SEND) begin
            acc_row_val    = tbl_row_q[idx_q];
            acc_column_val = tbl_col_q[idx_q];
            acc_value      = tbl_val_q[idx_q];
        end else if (state_q == S_SEND_TRN) begin
            acc_value = {5'd0, train_q};
        end
    end

endmodule

// File: tb/tb_csr_stream_host.sv
module tb_csr_stream_host;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_we = 1'b0;
    logic [3:0] cfg_addr = '0;
    logic [1:0] cfg_row = '0, cfg_col = '0;
    logic [7:0] cfg_val = '0;
    logic [3:0] nnz_count = '0;
    logic [2:0] train_in = '0;
    logic       go = 1'b0;
    logic       busy, done, error;
    logic [7:0] res0, res1, res2;
    logic       acc_start, acc_sending_cpu, acc_done_list;
    logic [1:0] acc_row_val, acc_column_val;
    logic [7:0] acc_value;
    logic       acc_fetch_ready;
    logic [7:0] acc_output_val;
    logic       acc_sending_out;

    logic rdy_en = 1'b1;   // bench can starve the handshake
    logic tb_tog = 1'b0;   // bench-injected sending_out toggles

    always #5 clk = ~clk;

    csr_stream_host dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_row(cfg_row), .cfg_col(cfg_col),
        .cfg_val(cfg_val), .nnz_count(nnz_count), .train_in(train_in), .go(go),
        .busy(busy), .done(done), .error(error),
        .res0(res0), .res1(res1), .res2(res2),
        .acc_start(acc_start), .acc_row_val(acc_row_val), .acc_column_val(acc_column_val),
        .acc_value(acc_value), .acc_sending_cpu(acc_sending_cpu), .acc_done_list(acc_done_list),
        .acc_fetch_ready(acc_fetch_ready), .acc_output_val(acc_output_val),
        .acc_sending_out(acc_sending_out)
    );

    // ---------------- behavioural accelerator ----------------
    logic       gap_q, got_dl_q, str_q, so_q;
    logic [1:0] m_row [16];
    logic [1:0] m_col [16];
    logic [7:0] m_val [16];
    logic [4:0] m_n;
    logic [2:0] m_trn, m_k;
    logic [1:0] m_w;
    logic [7:0] ov_q;
    logic [7:0] y [3];

    assign acc_fetch_ready = rdy_en & ~gap_q;
    assign acc_sending_out = so_q ^ tb_tog;
    assign acc_output_val  = ov_q;

    // y[row] = sum of values whose column is spiking
    always_comb begin
        y[0] = 8'd0; y[1] = 8'd0; y[2] = 8'd0;
        for (int i = 0; i < 16; i++)
            if (i < int'(m_n) && m_trn[m_col[i]] && m_row[i] < 2'd3)
                y[m_row[i]] = y[m_row[i]] + m_val[i];
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_q <= 1'b0; got_dl_q <= 1'b0; str_q <= 1'b0; so_q <= 1'b1;
            m_n <= '0; m_trn <= '0; m_k <= '0; m_w <= '0; ov_q <= '0;
        end else begin
            gap_q <= 1'b0;
            if (acc_start) begin
                m_n <= '0; got_dl_q <= 1'b0;
            end
            if (acc_sending_cpu && !got_dl_q) begin
                m_row[m_n[3:0]] <= acc_row_val;
                m_col[m_n[3:0]] <= acc_column_val;
                m_val[m_n[3:0]] <= acc_value;
                m_n <= m_n + 5'd1;
                gap_q <= 1'b1;
            end
            if (acc_done_list) begin
                got_dl_q <= 1'b1; gap_q <= 1'b1;
            end
            if (acc_sending_cpu && got_dl_q) begin
                m_trn <= acc_value[2:0]; str_q <= 1'b1; m_k <= '0; m_w <= 2'd3; gap_q <= 1'b1;
            end else if (str_q) begin
                if (m_w != 2'd0) m_w <= m_w - 2'd1;
                else begin
                    case (m_k)
                        3'd0:    ov_q <= 8'hA5;
                        3'd1:    ov_q <= y[0];
                        3'd2:    ov_q <= y[1];
                        default: ov_q <= y[2];
                    endcase
                    so_q <= ~so_q;
                    m_k  <= m_k + 3'd1;
                    m_w  <= 2'd2;
                    if (m_k == 3'd3) str_q <= 1'b0;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    int   cyc = 0, c_cpu = 0, c_dl = 0, c_start = 0, c_done = 0, c_err = 0;
    int   b2b = 0, both = 0, start_cyc = 0, err_cyc = 0;
    logic prev_s = 1'b0;
    logic [7:0] last_cpu_val = '0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (acc_start) begin c_start <= c_start + 1; start_cyc <= cyc + 1; end
        if (acc_sending_cpu) begin c_cpu <= c_cpu + 1; last_cpu_val <= acc_value; end
        if (acc_done_list) c_dl <= c_dl + 1;
        if (done) c_done <= c_done + 1;
        if (error) begin c_err <= c_err + 1; err_cyc <= cyc + 1; end
        if ((acc_sending_cpu | acc_done_list) && prev_s) b2b <= b2b + 1;
        if (done && error) both <= both + 1;
        prev_s <= acc_sending_cpu | acc_done_list;
    end

    // ---------------- checking helpers ----------------
    int n_chk = 0, n_pass = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(negedge clk); #1;
    endtask

    task automatic wr(input int a, input int r, input int c, input int v);
        cfg_we = 1'b1; cfg_addr = 4'(a); cfg_row = 2'(r); cfg_col = 2'(c); cfg_val = 8'(v);
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic start_go(input int nnz, input int trn);
        nnz_count = 4'(nnz); train_in = 3'(trn); go = 1'b1;
        tick();
        go = 1'b0;
    endtask

    task automatic wait_end(input string name);
        int t = 0;
        while (!(done || error) && t < 2000) begin tick(); t++; end
        if (!(done || error)) chk({name, "_end_timeout"}, 0, 1);
    endtask

    task automatic chk_res(input string name, input int r0, input int r1, input int r2);
        chk({name, "_res0"}, res0, r0);
        chk({name, "_res1"}, res1, r1);
        chk({name, "_res2"}, res2, r2);
    endtask

    typedef struct {
        int nnz; int trn; int r0; int r1; int r2; int ncpu;
    } vec_t;

    vec_t vecs [7];
    int   s_cpu, s_dl, s_start, s_done, s_err;

    task automatic snap();
        s_cpu = c_cpu; s_dl = c_dl; s_start = c_start; s_done = c_done; s_err = c_err;
    endtask

    initial begin
        // Table: 0:(0,0,5) 1:(1,1,7) 2:(2,2,9) 3:(0,1,2) 4:(1,2,3) 5:(2,0,4) 6:(0,2,1) 7:(1,0,6) 8:(2,1,8)
        vecs[0] = '{3,  3'b011, 5, 7,  0,  4};
        vecs[1] = '{3,  3'b111, 5, 7,  9,  4};
        vecs[2] = '{3,  3'b100, 0, 0,  9,  4};
        vecs[3] = '{0,  3'b111, 0, 0,  0,  1};
        vecs[4] = '{9,  3'b111, 8, 16, 21, 10};
        vecs[5] = '{15, 3'b001, 5, 6,  4,  10};   // clamped to 9
        vecs[6] = '{4,  3'b010, 2, 7,  0,  5};

        // reset state
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_start", acc_start, 0);
        chk("rst_cpu", acc_sending_cpu, 0);
        chk("rst_value", acc_value, 0);
        chk_res("rst", 0, 0, 0);
        @(negedge clk); #1; rst_n = 1'b1;
        tick();

        wr(0, 0, 0, 5); wr(1, 1, 1, 7); wr(2, 2, 2, 9);
        wr(3, 0, 1, 2); wr(4, 1, 2, 3); wr(5, 2, 0, 4);
        wr(6, 0, 2, 1); wr(7, 1, 0, 6); wr(8, 2, 1, 8);

        foreach (vecs[i]) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            snap();
            start_go(vecs[i].nnz, vecs[i].trn);
            wait_end(nm);
            chk({nm, "_done"}, done, 1);
            chk({nm, "_error"}, error, 0);
            chk({nm, "_busy"}, busy, 0);
            chk_res(nm, vecs[i].r0, vecs[i].r1, vecs[i].r2);
            chk({nm, "_ncpu"}, c_cpu - s_cpu, vecs[i].ncpu);
            chk({nm, "_ndl"}, c_dl - s_dl, 1);
            chk({nm, "_train"}, last_cpu_val, vecs[i].trn);
            tick();
            chk({nm, "_done_once"}, c_done - s_done, 1);
        end

        // write and go in the same idle cycle: launch sees the new entry
        snap();
        cfg_we = 1'b1; cfg_addr = 4'd0; cfg_row = 2'd0; cfg_col = 2'd0; cfg_val = 8'd50;
        start_go(1, 3'b001);
        cfg_we = 1'b0;
        wait_end("wrgo");
        chk_res("wrgo", 50, 0, 0);
        wr(0, 0, 0, 5);

        // timeout: no fetch_ready after START
        start_go(3, 3'b111); wait_end("pre_tmo"); tick();
        rdy_en = 1'b0;
        snap();
        start_go(3, 3'b011);
        wait_end("tmo");
        chk("tmo_error", error, 1);
        chk("tmo_done", done, 0);
        chk("tmo_busy", busy, 0);
        chk("tmo_latency", err_cyc - start_cyc, 256);
        chk("tmo_no_strobes", c_cpu - s_cpu, 0);
        chk_res("tmo", 5, 7, 9);
        tick();
        chk("tmo_err_once", c_err - s_err, 1);
        rdy_en = 1'b1;

        // table write while busy is dropped
        start_go(3, 3'b111);
        tick(); tick();
        chk("wbusy_busy", busy, 1);
        wr(2, 0, 0, 99);
        wait_end("wbusy1");
        chk_res("wbusy1", 5, 7, 9);
        tick();
        start_go(3, 3'b111);
        wait_end("wbusy2");
        chk_res("wbusy2", 5, 7, 9);
        tick();

        // reset in the middle of SEND
        start_go(3, 3'b011);
        for (int t = 0; t < 50 && !acc_sending_cpu; t++) tick();
        chk("rsend_seen", acc_sending_cpu, 1);
        rst_n = 1'b0;
        #1;
        chk("rsend_busy", busy, 0);
        chk("rsend_cpu", acc_sending_cpu, 0);
        chk("rsend_value", acc_value, 0);
        chk("rsend_row", acc_row_val, 0);
        chk_res("rsend", 0, 0, 0);
        @(negedge clk); #1; rst_n = 1'b1;
        tick();
        start_go(3, 3'b011);
        wait_end("rsend_after");
        chk("rsend_after_done", done, 1);
        chk_res("rsend_after", 5, 7, 0);
        tick();

        // go held across completion: exactly one relaunch after idle
        snap();
        nnz_count = 4'd3; train_in = 3'b111; go = 1'b1;
        tick();
        wait_end("hold1");
        chk("hold1_done", done, 1);
        chk("hold1_busy", busy, 0);
        tick();
        wait_end("hold2");
        go = 1'b0;
        chk("hold2_done", done, 1);
        chk_res("hold2", 5, 7, 9);
        tick(); tick(); tick();
        chk("hold_starts", c_start - s_start, 2);

        // stray toggles while idle cause no capture
        snap();
        for (int k = 0; k < 3; k++) begin
            tb_tog = ~tb_tog; tick(); tick();
        end
        chk("idle_tog_done", c_done - s_done, 0);
        chk("idle_tog_busy", busy, 0);
        chk_res("idle_tog", 5, 7, 9);

        chk("strobe_b2b", b2b, 0);
        chk("done_err_overlap", both, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
